alu_stage_pipe: RTL and testbench
=================================

# alu_stage_pipe

Parametrised, registered successor to the combinational ALU stage. It accepts one operation per handshake, selects operand B from the register file or the immediate, and returns a registered result with Zero/Ovf flags. Shifts and rotates by a variable amount run on an iterative one-bit-per-cycle shifter. The block sits in the EX stage between ID/EX operand latching and the EX/MEM register, and stalls the pipe through its ready/valid handshake.

## Interface
- WIDTH, 32, datapath width (≥ 8, power of two)
- SHAMT_W, $clog2(WIDTH), shift-amount field width (derived; do not override)
- Clk  in  1  clock, all state updates on rising edge
- Rst_n  in  1  reset, asynchronous, active-low
- In_valid  in  1  operation offered
- In_ready  out  1  block can accept this cycle
- RF_A  in  WIDTH  operand A
- RF_B  in  WIDTH  register operand B
- Immed  in  WIDTH  immediate, already extended to WIDTH
- ALU_Bin_sel  in  1  0 selects RF_B, 1 selects Immed
- ALU_func  in  4  opcode
- Out_valid  out  1  result held and valid
- Out_ready  in  1  consumer takes result
- ALU_out  out  WIDTH  registered result
- Zero  out  1  ALU_out == 0
- Ovf  out  1  signed overflow (add/sub only)

## Operation
- B = ALU_Bin_sel ? Immed : RF_B. Operands are captured on accept (In_valid && In_ready).
- Opcodes:
  - 0000 add A+B; 0001 sub A−B; 0010 and; 0011 or; 0100 not A; 0101 xor; 0110 nor.
  - 1000 sra; 1001 srl; 1010 sll; 1100 rotl; 1101 rotr.
  - Any other code yields 0, Zero=1, Ovf=0.
- Arithmetic is modulo 2^WIDTH. Ovf is set when:
  - add: both operand signs are equal and the result sign differs;
  - sub: the operand signs differ and the result sign differs from A.
- Shift amount n = B[SHAMT_W-1:0]; upper bits of B are ignored.
- FSM states:
  - IDLE: non-shift accept loads the result directly, sets Out_valid → stays IDLE. Shift accept with n=0 loads A, sets Out_valid → IDLE. Shift accept with n≥1 loads the work register with A and the counter with n → SHIFT.
  - SHIFT: each cycle shifts or rotates the work register by one bit and decrements the counter. On the cycle the counter reaches 0, the work register goes to ALU_out and Out_valid sets → IDLE.
- Out_valid stays high with ALU_out, Zero and Ovf stable until Out_ready is sampled high. It then clears, unless a new result loads on the same edge.
- In_ready = (state==IDLE) && (!Out_valid || Out_ready). This gives back-to-back single-cycle throughput while the consumer is ready.
- The FSM never accepts during SHIFT.

## Timing
- Reset values: ALU_out=0, Zero=1, Ovf=0, Out_valid=0, state IDLE, counter 0, work register 0.
- In_ready is 1 one cycle after reset release.
- Latency is measured from the accept edge to Out_valid visible:
  - non-shift ops and shifts with n=0: 1 cycle;
  - shifts with n≥1: n+1 cycles.
- A shift with n=WIDTH−1 is the worst case, at WIDTH cycles.
- Simultaneous Out_ready and accept: the old result retires and the new result loads on the same edge, so Out_valid stays high.
- Reset asserted mid-SHIFT aborts the operation immediately. All outputs return to their reset values, and no partial result is ever presented.
- Input changes while In_ready=0 have no effect.

## Configuration
- ALU_ITER_SHIFT_EN defined: behaviour as above, with variable-amount iterative shifts and the SHIFT state present.
- ALU_ITER_SHIFT_EN undefined:
  - The SHIFT state and counter are removed.
  - Every shift or rotate is by exactly 1, ignoring B, and completes in 1 cycle like other ops.
  - In_ready = !Out_valid || Out_ready.

## Structure
- Shared package alu_pkg holds:
  - the 4-bit opcode localparams (ALU_ADD … ALU_ROTR);
  - the FSM state typedef (IDLE, SHIFT);
  - a helper function for the signed-overflow rule.
- One sub-module, alu_iter_shifter, holds the work register, the counter and the one-bit step logic. It exposes start, n, mode, busy, done and result. The top level holds the operand mux, the combinational ops, the output register and the handshake.

## Test plan
- Reset mid-shift: Rst_n low during an n=20 shift → Out_valid=0, ALU_out=0, Zero=1 immediately. After release, In_ready=1 in the next cycle.
- Add with immediate: RF_A=1, Immed=12, ALU_Bin_sel=1, func 0000 → ALU_out=13, Zero=0, Ovf=0 one cycle after accept. Then RF_A=0x7FFFFFFF, RF_B=1, func 0000 → ALU_out=0x80000000, Ovf=1.
- Back-to-back accepts: RF_A=1, RF_B=4 with func 0011, then func 0100, Out_ready held high → 5 then 0xFFFFFFFE on consecutive cycles; In_ready stays 1.
- Rotate right: RF_A=0x00000001, RF_B=4, func 1101 →
  - with ALU_ITER_SHIFT_EN: In_ready low for 4 cycles, then ALU_out=0x10000000 at latency 5;
  - without: ALU_out=0x80000000 at latency 1.
- Backpressure: Out_ready=0 for 3 cycles after a sub of 4−4 → ALU_out=0 and Zero=1 held stable, In_ready=0. Raise Out_ready together with a new In_valid → the result retires and the new op is accepted on the same edge.
- Illegal opcode and n=0: func 1111 → ALU_out=0, Zero=1. Func 1010 with B=32 (n=0) → ALU_out=RF_A at latency 1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the EX-stage ALU (alu_stage_pipe).
//   * 4-bit opcode encodings ALU_ADD .. ALU_ROTR
//   * FSM state type for the iterative shift sequencer
//   * signed-overflow helper for add/sub
//   * shift/rotate opcode classifier
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_NOT  = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_NOR  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SLL  = 4'b1010;
  localparam logic [3:0] ALU_ROTL = 4'b1100;
  localparam logic [3:0] ALU_ROTR = 4'b1101;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } alu_state_e;

  // Signed overflow from the operand and result sign bits.
  // add: operands agree in sign and the result disagrees.
  // sub: operands differ in sign and the result disagrees with A.
  function automatic logic add_sub_ovf(input logic is_sub, input logic a_msb,
                                       input logic b_msb, input logic r_msb);
    if (is_sub) begin
      return (a_msb != b_msb) && (r_msb != a_msb);
    end
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  function automatic logic is_shift_op(input logic [3:0] func);
    return (func == ALU_SRA) || (func == ALU_SRL) || (func == ALU_SLL) ||
           (func == ALU_ROTL) || (func == ALU_ROTR);
  endfunction

endpackage

// File: rtl/alu_stage_pipe_if.sv
// alu_stage_pipe_if -- operand/result handshake bundle of the EX-stage ALU.
//   Upstream (ID/EX): In_valid, In_ready, RF_A, RF_B, Immed, ALU_Bin_sel, ALU_func
//   Downstream (EX/MEM): Out_valid, Out_ready, ALU_out, Zero, Ovf
//   modport master : the pipeline driving operations and consuming results
//   modport slave  : the ALU itself
interface alu_stage_pipe_if #(parameter int WIDTH = 32);

  logic             In_valid;
  logic             In_ready;
  logic [WIDTH-1:0] RF_A;
  logic [WIDTH-1:0] RF_B;
  logic [WIDTH-1:0] Immed;
  logic             ALU_Bin_sel;
  logic [3:0]       ALU_func;
  logic             Out_valid;
  logic             Out_ready;
  logic [WIDTH-1:0] ALU_out;
  logic             Zero;
  logic             Ovf;

  modport master (
    output In_valid, RF_A, RF_B, Immed, ALU_Bin_sel, ALU_func, Out_ready,
    input  In_ready, Out_valid, ALU_out, Zero, Ovf
  );

  modport slave (
    input  In_valid, RF_A, RF_B, Immed, ALU_Bin_sel, ALU_func, Out_ready,
    output In_ready, Out_valid, ALU_out, Zero, Ovf
  );

endinterface

// File: rtl/alu_iter_shifter.sv
// alu_iter_shifter -- one-bit-per-cycle shifter/rotator.
// Ports:
//   Clk, Rst_n   clock, asynchronous active-low reset
//   start_i      load a_i / n_i / mode_i (only issued with n_i >= 1)
//   n_i          number of one-bit steps
//   mode_i       shift opcode (ALU_SRA/SRL/SLL/ROTL/ROTR)
//   a_i          value to shift
//   busy_o       a shift is in progress
//   done_o       final step happens on this edge; result_o is the final value
//   result_o     work register advanced by one step (valid with done_o)
module alu_iter_shifter
  import alu_pkg::*;
#(
  parameter  int WIDTH   = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               start_i,
  input  logic [SHAMT_W-1:0] n_i,
  input  logic [3:0]         mode_i,
  input  logic [WIDTH-1:0]   a_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [WIDTH-1:0]   result_o
);

  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [3:0]         mode_q, mode_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   step_val;

  function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] w,
                                             input logic [3:0] m);
    case (m)
      ALU_SRA:  return {w[WIDTH-1], w[WIDTH-1:1]};
      ALU_SRL:  return {1'b0, w[WIDTH-1:1]};
      ALU_SLL:  return {w[WIDTH-2:0], 1'b0};
      ALU_ROTL: return {w[WIDTH-2:0], w[WIDTH-1]};
      ALU_ROTR: return {w[0], w[WIDTH-1:1]};
      default:  return w;
    endcase
  endfunction

  assign step_val = step1(work_q, mode_q);

  // The counter holds the steps still to do; the step that takes it from
  // 1 to 0 is the last one, so the top captures step_val on that edge.
  assign done_o   = busy_q && (cnt_q == SHAMT_W'(1));
  assign busy_o   = busy_q;
  assign result_o = step_val;

  always_comb begin
    work_d = work_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    busy_d = busy_q;
    if (start_i) begin
      work_d = a_i;
      cnt_d  = n_i;
      mode_d = mode_i;
      busy_d = 1'b1;
    end else if (busy_q) begin
      work_d = step_val;
      cnt_d  = cnt_q - SHAMT_W'(1);
      if (cnt_q == SHAMT_W'(1)) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      work_q <= '0;
      cnt_q  <= '0;
      mode_q <= ALU_SLL;
      busy_q <= 1'b0;
    end else begin
      work_q <= work_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/alu_stage_pipe.sv
// alu_stage_pipe -- registered EX-stage ALU with ready/valid handshake.
// Ports:
//   Clk    clock, rising edge
//   Rst_n  asynchronous active-low reset
//   bus    alu_stage_pipe_if.slave: operands/opcode in, ALU_out/Zero/Ovf out
// Build option ALU_ITER_SHIFT_EN:
//   defined   -> shifts/rotates by B[SHAMT_W-1:0] on alu_iter_shifter, n+1 cycles
//   undefined -> every shift/rotate is by exactly one bit, single cycle
module alu_stage_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  alu_stage_pipe_if.slave      bus
);

  logic [WIDTH-1:0] a, b, sum, diff;
  logic [WIDTH-1:0] res_d;
  logic             ovf_d;
  logic             accept;
  logic             in_ready;
  logic             load_d;
  logic [WIDTH-1:0] load_val_d;
  logic             load_ovf_d;

  logic [WIDTH-1:0] out_q;
  logic             zero_q;
  logic             ovf_q;
  logic             valid_q;

  assign a    = bus.RF_A;
  assign b    = bus.ALU_Bin_sel ? bus.Immed : bus.RF_B;
  assign sum  = a + b;
  assign diff = a - b;

  // Single-cycle result for everything except a multi-step shift.
  always_comb begin
    res_d = '0;
    ovf_d = 1'b0;
    case (bus.ALU_func)
      ALU_ADD: begin
        res_d = sum;
        ovf_d = add_sub_ovf(1'b0, a[WIDTH-1], b[WIDTH-1], sum[WIDTH-1]);
      end
      ALU_SUB: begin
        res_d = diff;
        ovf_d = add_sub_ovf(1'b1, a[WIDTH-1], b[WIDTH-1], diff[WIDTH-1]);
      end
      ALU_AND: res_d = a & b;
      ALU_OR:  res_d = a | b;
      ALU_NOT: res_d = ~a;
      ALU_XOR: res_d = a ^ b;
      ALU_NOR: res_d = ~(a | b);
`ifdef ALU_ITER_SHIFT_EN
      // Only the n=0 case completes here; it passes A through unchanged.
      ALU_SRA, ALU_SRL, ALU_SLL, ALU_ROTL, ALU_ROTR: res_d = a;
`else
      ALU_SRA:  res_d = {a[WIDTH-1], a[WIDTH-1:1]};
      ALU_SRL:  res_d = {1'b0, a[WIDTH-1:1]};
      ALU_SLL:  res_d = {a[WIDTH-2:0], 1'b0};
      ALU_ROTL: res_d = {a[WIDTH-2:0], a[WIDTH-1]};
      ALU_ROTR: res_d = {a[0], a[WIDTH-1:1]};
`endif
      default: ;
    endcase
  end

`ifdef ALU_ITER_SHIFT_EN
  localparam int SHAMT_W = $clog2(WIDTH);

  alu_state_e         state_q;
  logic [SHAMT_W-1:0] n;
  logic               start_shift;
  logic               sh_busy;
  logic               sh_done;
  logic [WIDTH-1:0]   sh_result;

  // Upper bits of B beyond the shift-amount field are ignored.
  assign n           = b[SHAMT_W-1:0];
  assign in_ready    = (state_q == IDLE) && !sh_busy && (!valid_q || bus.Out_ready);
  assign accept      = bus.In_valid && in_ready;
  assign start_shift = accept && is_shift_op(bus.ALU_func) && (n != '0);

  // sh_done only occurs in SHIFT, where nothing can be accepted, so the
  // two load sources never collide.
  assign load_d      = (accept && !start_shift) || sh_done;
  assign load_val_d  = sh_done ? sh_result : res_d;
  assign load_ovf_d  = sh_done ? 1'b0 : ovf_d;

  alu_iter_shifter #(.WIDTH(WIDTH)) u_shifter (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .start_i  (start_shift),
    .n_i      (n),
    .mode_i   (bus.ALU_func),
    .a_i      (a),
    .busy_o   (sh_busy),
    .done_o   (sh_done),
    .result_o (sh_result)
  );
`else
  assign in_ready   = !valid_q || bus.Out_ready;
  assign accept     = bus.In_valid && in_ready;
  assign load_d     = accept;
  assign load_val_d = res_d;
  assign load_ovf_d = ovf_d;
`endif

  // Output register and sequencer. A new load wins over retirement, so a
  // retire-and-accept on the same edge keeps Out_valid high.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      out_q   <= '0;
      zero_q  <= 1'b1;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
`ifdef ALU_ITER_SHIFT_EN
      state_q <= IDLE;
`endif
    end else begin
      if (load_d) begin
        out_q   <= load_val_d;
        zero_q  <= (load_val_d == '0);
        ovf_q   <= load_ovf_d;
        valid_q <= 1'b1;
      end else if (bus.Out_ready) begin
        valid_q <= 1'b0;
      end
`ifdef ALU_ITER_SHIFT_EN
      case (state_q)
        IDLE:    if (start_shift) state_q <= SHIFT;
        SHIFT:   if (sh_done)     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
`endif
    end
  end

  assign bus.In_ready  = in_ready;
  assign bus.Out_valid = valid_q;
  assign bus.ALU_out   = out_q;
  assign bus.Zero      = zero_q;
  assign bus.Ovf       = ovf_q;

endmodule

// File: tb/tb_alu_stage_pipe.sv
// tb_alu_stage_pipe -- directed self-checking bench for alu_stage_pipe.
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected shift results follow the ALU_ITER_SHIFT_EN build option.
module tb_alu_stage_pipe;

`ifdef ALU_ITER_SHIFT_EN
  localparam bit ITER = 1'b1;
`else
  localparam bit ITER = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  alu_stage_pipe_if #(.WIDTH(32)) bus ();

  alu_stage_pipe #(.WIDTH(32)) dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Offer one op at a falling edge, wait for its result; returns latency in
  // cycles (1 = visible right after the accept edge) and the number of
  // cycles In_ready was low while waiting.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic sel, input logic [3:0] f,
                       output int lat, output int low);
    int guard;
    guard = 0;
    bus.RF_A        = a;
    bus.RF_B        = b;
    bus.Immed       = imm;
    bus.ALU_Bin_sel = sel;
    bus.ALU_func    = f;
    bus.In_valid    = 1'b1;
    while (!bus.In_ready && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_in_ready"}, 32'(bus.In_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.In_valid = 1'b0;
    lat = 1;
    low = 0;
    while (!bus.Out_valid && lat < 100) begin
      if (!bus.In_ready) low++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic sel, input logic [3:0] f,
                         input logic [31:0] exp_out, input logic exp_ovf,
                         input int exp_lat, input int exp_low);
    int lat, low;
    do_op(tag, a, b, imm, sel, f, lat, low);
    $display("op %s f=%b a=%h b=%h imm=%h sel=%b -> out=%h zero=%b ovf=%b lat=%0d",
             tag, f, a, b, imm, sel, bus.ALU_out, bus.Zero, bus.Ovf, lat);
    chk({tag, "_out"},  bus.ALU_out, exp_out);
    chk({tag, "_zero"}, 32'(bus.Zero), 32'(exp_out == 32'd0));
    chk({tag, "_ovf"},  32'(bus.Ovf), 32'(exp_ovf));
    chk({tag, "_lat"},  32'(lat), 32'(exp_lat));
    chk({tag, "_rdylow"}, 32'(low), 32'(exp_low));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.In_valid    = 1'b0;
    bus.RF_A        = '0;
    bus.RF_B        = '0;
    bus.Immed       = '0;
    bus.ALU_Bin_sel = 1'b0;
    bus.ALU_func    = 4'b0000;
    bus.Out_ready   = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_out",   bus.ALU_out, 32'd0);
    chk("rst_zero",  32'(bus.Zero), 32'd1);
    chk("rst_ovf",   32'(bus.Ovf), 32'd0);
    chk("rst_valid", 32'(bus.Out_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.In_ready), 32'd1);

    // Reset in the middle of a 20-step shift.
    bus.RF_A = 32'd1; bus.RF_B = 32'd20; bus.ALU_Bin_sel = 1'b0;
    bus.ALU_func = 4'b1010; bus.In_valid = 1'b1;
    @(negedge clk);
    bus.In_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(bus.Out_valid), 32'd0);
    chk("midrst_out",   bus.ALU_out, 32'd0);
    chk("midrst_zero",  32'(bus.Zero), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 32'(bus.In_ready), 32'd1);
    repeat (25) @(negedge clk);
    chk("midrst_no_late_valid", 32'(bus.Out_valid), 32'd0);

    // Directed vectors: tag, A, RF_B, Immed, sel, func, out, ovf, latency, ready-low cycles.
    run_vec("add_imm",  32'd1,         32'h0000DEAD, 32'd12, 1'b1, 4'b0000, 32'd13,        1'b0, 1, 0);
    run_vec("add_ovf",  32'h7FFFFFFF,  32'd1,        32'd0,  1'b0, 4'b0000, 32'h80000000,  1'b1, 1, 0);
    run_vec("sub_ovf",  32'h80000000,  32'd1,        32'd0,  1'b0, 4'b0001, 32'h7FFFFFFF,  1'b1, 1, 0);
    run_vec("sub_neg",  32'd3,         32'd5,        32'd0,  1'b0, 4'b0001, 32'hFFFFFFFE,  1'b0, 1, 0);
    run_vec("and",      32'hF0F0F0F0,  32'hFF00FF00, 32'd0,  1'b0, 4'b0010, 32'hF000F000,  1'b0, 1, 0);
    run_vec("xor",      32'hF0F0F0F0,  32'hFF00FF00, 32'd0,  1'b0, 4'b0101, 32'h0FF00FF0,  1'b0, 1, 0);
    run_vec("nor",      32'hF0F0F0F0,  32'h0F0F0F0F, 32'd0,  1'b0, 4'b0110, 32'h00000000,  1'b0, 1, 0);
    run_vec("rotr4",    32'h00000001,  32'd4,        32'd0,  1'b0, 4'b1101,
            ITER ? 32'h10000000 : 32'h80000000, 1'b0, ITER ? 5 : 1, ITER ? 4 : 0);
    run_vec("sra3",     32'h80000000,  32'd3,        32'd0,  1'b0, 4'b1000,
            ITER ? 32'hF0000000 : 32'hC0000000, 1'b0, ITER ? 4 : 1, ITER ? 3 : 0);
    run_vec("srl31",    32'h80000000,  32'hFFFFFFFF, 32'd0,  1'b0, 4'b1001,
            ITER ? 32'h00000001 : 32'h40000000, 1'b0, ITER ? 32 : 1, ITER ? 31 : 0);
    run_vec("rotl1",    32'h80000001,  32'd0,        32'd1,  1'b1, 4'b1100, 32'h00000003,  1'b0, ITER ? 2 : 1, ITER ? 1 : 0);
    run_vec("sll4",     32'h0000000F,  32'd4,        32'd0,  1'b0, 4'b1010,
            ITER ? 32'h000000F0 : 32'h0000001E, 1'b0, ITER ? 5 : 1, ITER ? 4 : 0);
    run_vec("sll_n0",   32'h00000A5A,  32'd32,       32'd0,  1'b0, 4'b1010,
            ITER ? 32'h00000A5A : 32'h000014B4, 1'b0, 1, 0);
    run_vec("ill_1111", 32'h00001234,  32'd7,        32'd0,  1'b0, 4'b1111, 32'd0,         1'b0, 1, 0);
    run_vec("ill_0111", 32'hFFFFFFFF,  32'd7,        32'd0,  1'b0, 4'b0111, 32'd0,         1'b0, 1, 0);

    // Back-to-back accepts with the consumer always ready.
    bus.RF_A = 32'd1; bus.RF_B = 32'd4; bus.ALU_Bin_sel = 1'b0;
    bus.ALU_func = 4'b0011; bus.In_valid = 1'b1; bus.Out_ready = 1'b1;
    chk("b2b_rdy0", 32'(bus.In_ready), 32'd1);
    @(negedge clk);
    chk("b2b_out0",   bus.ALU_out, 32'd5);
    chk("b2b_valid0", 32'(bus.Out_valid), 32'd1);
    chk("b2b_rdy1",   32'(bus.In_ready), 32'd1);
    bus.ALU_func = 4'b0100;
    @(negedge clk);
    bus.In_valid = 1'b0;
    chk("b2b_out1",   bus.ALU_out, 32'hFFFFFFFE);
    chk("b2b_valid1", 32'(bus.Out_valid), 32'd1);
    $display("op b2b or/not -> out=%h", bus.ALU_out);
    @(negedge clk);
    chk("b2b_retired", 32'(bus.Out_valid), 32'd0);

    // Backpressure: result of 4-4 held; a pending offer has no effect
    // until Out_ready rises, then retire and accept share one edge.
    bus.Out_ready = 1'b0;
    bus.RF_A = 32'd4; bus.RF_B = 32'd4; bus.ALU_func = 4'b0001; bus.In_valid = 1'b1;
    @(negedge clk);
    bus.RF_A = 32'd2; bus.RF_B = 32'd3; bus.ALU_func = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      chk("bp_out",   bus.ALU_out, 32'd0);
      chk("bp_zero",  32'(bus.Zero), 32'd1);
      chk("bp_valid", 32'(bus.Out_valid), 32'd1);
      chk("bp_rdy",   32'(bus.In_ready), 32'd0);
      @(negedge clk);
    end
    bus.Out_ready = 1'b1;
    #1;
    chk("bp_rdy_release", 32'(bus.In_ready), 32'd1);
    @(negedge clk);
    bus.In_valid = 1'b0;
    chk("bp_new_out",   bus.ALU_out, 32'd5);
    chk("bp_new_zero",  32'(bus.Zero), 32'd0);
    chk("bp_new_valid", 32'(bus.Out_valid), 32'd1);
    $display("op backpressure sub->add -> out=%h", bus.ALU_out);
    @(negedge clk);
    chk("bp_retired", 32'(bus.Out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
